// File: rtl/sha3_arbiter.sv
// Two-requester arbiter in front of a single SHA3TOP core. A grant is held from a
// message's first block until its digest returns; grants alternate round-robin on contention.
module sha3_arbiter #(
   parameter int DATA_W = 1088,
   parameter int OUT_W  = 256
) (
   input  logic              clk,
   input  logic              rst,

   input  logic [DATA_W-1:0] r0_in,
   input  logic              r0_more,
   input  logic              r0_valid,
   output logic              r0_ack,
   output logic              r0_next,
   output logic              r0_done,

   input  logic [DATA_W-1:0] r1_in,
   input  logic              r1_more,
   input  logic              r1_valid,
   output logic              r1_ack,
   output logic              r1_next,
   output logic              r1_done,

   output logic [OUT_W-1:0]  out,
   output logic              busy,
   output logic              owner,

   output logic [DATA_W-1:0] core_in,
   output logic              core_more,
   output logic              core_in_valid,
   input  logic [OUT_W-1:0]  core_out,
   input  logic              core_hash_next,
   input  logic              core_out_valid
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic                ptr_q, ptr_d;
   logic                expect_q, expect_d;
   logic                owner_q, owner_d;
   logic                busy_q, busy_d;
   logic [DATA_W-1:0]   core_in_q, core_in_d;
   logic                core_more_q, core_more_d;
   logic                core_in_valid_q, core_in_valid_d;
   logic [OUT_W-1:0]    out_q, out_d;
   logic [1:0]          ack_q, ack_d;
   logic [1:0]          next_q, next_d;
   logic [1:0]          done_q, done_d;

   logic [1:0]          req_valid;
   logic                grant_idx;
   logic                owner_valid;
   logic [DATA_W-1:0]   owner_in;
   logic                owner_more;

   assign req_valid = {r1_valid, r0_valid};

   // A lone requester wins outright; on a tie the round-robin pointer decides.
   assign grant_idx   = (req_valid == 2'b11) ? ptr_q : r1_valid;
   assign owner_valid = owner_q ? r1_valid : r0_valid;
   assign owner_in    = owner_q ? r1_in    : r0_in;
   assign owner_more  = owner_q ? r1_more  : r0_more;

   always_comb begin
      // NOTE: every *_d gets its default here, so no path through the case infers a latch.
      state_d         = state_q;
      ptr_d           = ptr_q;
      expect_d        = expect_q;
      owner_d         = owner_q;
      busy_d          = busy_q;
      core_in_d       = core_in_q;
      core_more_d     = core_more_q;
      core_in_valid_d = 1'b0;
      out_d           = out_q;
      ack_d           = 2'b00;
      next_d          = 2'b00;
      done_d          = 2'b00;

      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               state_d            = BUSY;
               busy_d             = 1'b1;
               owner_d            = grant_idx;
               expect_d           = 1'b0;
               core_in_d          = grant_idx ? r1_in   : r0_in;
               core_more_d        = grant_idx ? r1_more : r0_more;
               core_in_valid_d    = 1'b1;
               ack_d[grant_idx]   = 1'b1;
            end
         end

         BUSY: begin
            // A digest ends the message even if the core also raised hash_next.
            if (core_out_valid) begin
               out_d            = core_out;
               done_d[owner_q]  = 1'b1;
               busy_d           = 1'b0;
               state_d          = IDLE;
               ptr_d            = ~owner_q;
               expect_d         = 1'b0;
            end else if (core_hash_next) begin
               expect_d         = 1'b1;
               next_d[owner_q]  = 1'b1;
            end else if (expect_q && owner_valid) begin
               core_in_d        = owner_in;
               core_more_d      = owner_more;
               core_in_valid_d  = 1'b1;
               ack_d[owner_q]   = 1'b1;
               expect_d         = 1'b0;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         ptr_q           <= 1'b0;
         expect_q        <= 1'b0;
         owner_q         <= 1'b0;
         busy_q          <= 1'b0;
         // NOTE: the wide data registers are reset too, since core_in and out are defined as zero after reset.
         core_in_q       <= '0;
         core_more_q     <= 1'b0;
         core_in_valid_q <= 1'b0;
         out_q           <= '0;
         ack_q           <= 2'b00;
         next_q          <= 2'b00;
         done_q          <= 2'b00;
      end else begin
         state_q         <= state_d;
         ptr_q           <= ptr_d;
         expect_q        <= expect_d;
         owner_q         <= owner_d;
         busy_q          <= busy_d;
         core_in_q       <= core_in_d;
         core_more_q     <= core_more_d;
         core_in_valid_q <= core_in_valid_d;
         out_q           <= out_d;
         ack_q           <= ack_d;
         next_q          <= next_d;
         done_q          <= done_d;
      end
   end

   assign r0_ack        = ack_q[0];
   assign r1_ack        = ack_q[1];
   assign r0_next       = next_q[0];
   assign r1_next       = next_q[1];
   assign r0_done       = done_q[0];
   assign r1_done       = done_q[1];
   assign out           = out_q;
   assign busy          = busy_q;
   assign owner         = owner_q;
   assign core_in       = core_in_q;
   assign core_more     = core_more_q;
   assign core_in_valid = core_in_valid_q;

endmodule

// File: doc/sha3_arbiter.md
Name: sha3_arbiter

Overview:
- Shares one SHA3TOP core between two requesters (e.g. the HMAC controller and a raw-hash client).
- Each requester sends a message of one or more 1088-bit blocks. The grant is locked to one requester from its first block until the core reports its digest.
- Round-robin between messages. All core-side and requester-side control is registered.

Parameters:
- DATA_W, 1088, block width; the SHA3-256 rate
- OUT_W, 256, digest width

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- r0_in  input  DATA_W  requester 0 block data
- r0_more  input  1  1 = more blocks follow this one
- r0_valid  input  1  requester 0 block valid; held until r0_ack
- r0_ack  output  1  one-cycle pulse: block latched
- r0_next  output  1  one-cycle pulse: core ready for the next block
- r0_done  output  1  one-cycle pulse: digest on out is requester 0's
- r1_in, r1_more, r1_valid, r1_ack, r1_next, r1_done: identical set for requester 1
- out  output  OUT_W  registered digest, held until the next done
- busy  output  1  1 while a grant is active
- owner  output  1  current or last grantee index
- core_in  output  DATA_W  to SHA3TOP in
- core_more  output  1  to SHA3TOP more
- core_in_valid  output  1  to SHA3TOP in_valid; one-cycle pulse
- core_out  input  OUT_W  from SHA3TOP out
- core_hash_next  input  1  from SHA3TOP hash_next
- core_out_valid  input  1  from SHA3TOP out_valid

Behaviour:
- Reset values:
  - all pulses 0
  - core_in = 0, core_more = 0, out = 0
  - busy = 0, owner = 0
  - state IDLE, round-robin pointer ptr = 0, internal flag expect = 0
- States are IDLE and BUSY.
- IDLE:
  - If any rN_valid is high at edge t: grantee = the requester whose valid is high; if both are high, grantee = ptr.
  - Latch the grantee's in/more into core_in/core_more.
  - During cycle t+1: rN_ack = 1, core_in_valid = 1, busy = 1, owner = grantee; state goes to BUSY.
  - Latency valid-to-core = 1 cycle.
- BUSY, core_out_valid = 1 at edge e:
  - Latch out = core_out.
  - During e+1: r[owner]_done = 1, busy = 0, state IDLE, ptr = !owner, expect = 0.
  - A new grant can be sampled at edge e+1, giving core_in_valid at e+2.
- BUSY, core_hash_next = 1 at edge c (and core_out_valid = 0):
  - During c+1: expect = 1 and r[owner]_next = 1.
- BUSY, expect = 1 and r[owner]_valid = 1 at edge d:
  - Latch the block.
  - During d+1: ack = 1, core_in_valid = 1, expect = 0.
- BUSY, owner valid while expect = 0: ignored, no ack. This covers valid still high in the ack cycle.
- BUSY, non-owner valid: ignored; it stays pending and wins the next IDLE arbitration via ptr.
- core_out_valid and core_hash_next in the same cycle: out_valid wins; next is dropped.
- core_out_valid or core_hash_next in IDLE: ignored, no pulses, out unchanged.
- core_in/core_more hold their last latched value between pulses.
- Only the grantee ever gets ack/next/done. Pulses never go to both requesters in the same cycle.
- Reset mid-message: returns to reset values on the next edge. The core shares rst, so no core state survives.
- No timeout. A requester that never supplies its next block holds the core indefinitely; this is the requester's responsibility.

Test Plan:
- Single block: r0_valid with in = {1088{1'b1}}, more = 0 -> r0_ack and core_in_valid high one cycle later with core_in equal to the input. Core out_valid with core_out = 256'hA5…A5 -> r0_done next cycle, out = A5…A5, busy = 0, ptr = 1.
- Two-block message on r1 (first block more = 1, then more = 0): first ack; core_hash_next -> r1_next 1 cycle later. r1 second block -> second core_in_valid with core_more = 0. Exactly 2 core_in_valid pulses before r1_done.
- Contention: r0_valid and r1_valid both high from reset -> r0 granted first, r1 held with no ack. After r0_done, r1 is granted at the next edge. Repeated simultaneous requests alternate 0,1,0,1.
- Lock: during a multi-block r0 message, r1_valid pulses mid-message -> no r1_ack and core_in never carries r1 data until r0_done.
- Simultaneous core_hash_next and core_out_valid -> done only, no next, expect = 0. Stray core_out_valid in IDLE -> no pulses, out unchanged.
- rst asserted between two blocks of a message -> next cycle busy = 0, all pulses 0, ptr = 0. A fresh r1 request afterwards is granted normally.
